// File: rtl/irq_sequencer_pkg.sv
// Shared definitions for the interrupt entry/exit sequencer: FSM encoding and
// the width helpers used to size the PC word count and source index.
package irq_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRAIN  = 3'd1,
      S_PUSH   = 3'd2,
      S_VECTOR = 3'd3,
      S_POP    = 3'd4,
      S_RESUME = 3'd5
   } state_t;

   function automatic int calc_pc_words(input int addr_w, input int data_w);
      return (addr_w + data_w - 1) / data_w;
   endfunction

   function automatic int calc_id_w(input int n_irq);
      return (n_irq > 1) ? $clog2(n_irq) : 1;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/irq_sequencer_prio.sv
// Fixed-priority arbiter over the eligible interrupt sources; the lowest
// index wins.
module irq_priority_encoder #(
   parameter int N_IRQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_IRQ-1:0] req_i,
   output logic             valid_o,
   output logic [ID_W-1:0]  id_o
);

   always_comb begin
      valid_o = |req_i;
      id_o    = '0;
      // Descending scan so the last hit, the lowest index, is the one kept.
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (req_i[i]) id_o = ID_W'(i);
      end
   end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer: drains the pipeline, pushes PC and CCR,
// vectors to the handler, and restores PC/CCR on RTI.
module irq_sequencer
   import irq_sequencer_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 32,
   parameter int FLAG_W       = 3,
   parameter int N_IRQ        = 4,
   parameter int DRAIN_CYCLES = 3,
   parameter int VEC_BASE     = 0,
   parameter int VEC_STRIDE   = 2,
   localparam int PC_WORDS    = calc_pc_words(ADDR_W, DATA_W),
   localparam int ID_W        = calc_id_w(N_IRQ)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_IRQ-1:0]  irq,
   input  logic [N_IRQ-1:0]  irq_mask,
   input  logic [ADDR_W-1:0] pc_resume,
   input  logic [FLAG_W-1:0] ccr_in,
   input  logic              branch_pending,
   input  logic              rti,
   input  logic              push_ready,
   input  logic              pop_valid,
   input  logic [DATA_W-1:0] pop_data,
   output logic              stall_fetch,
   output logic              flush,
   output logic              push_req,
   output logic [DATA_W-1:0] push_data,
   output logic              pop_req,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_load_value,
   output logic              ccr_load,
   output logic [FLAG_W-1:0] ccr_load_value,
   output logic              in_service,
   output logic [ID_W-1:0]   active_id,
   output logic              spurious_rti,
   output state_t            dbg_state
);

   // Handshakes: a push word transfers on a cycle with push_req && push_ready,
   // and push_data is held stable while push_req && !push_ready. A pop beat is
   // consumed on a cycle with pop_req && pop_valid; pop_valid alone is ignored.

   localparam int PCW     = PC_WORDS * DATA_W;
   localparam int CNT_MAX = max2(DRAIN_CYCLES, PC_WORDS + 1);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(PC_WORDS);

   state_t              state_q, state_d;
   logic [N_IRQ-1:0]    irq_q;
   logic                arm_q;
   logic [N_IRQ-1:0]    pend_q, pend_d;
   logic [ID_W-1:0]     active_id_q, active_id_d;
   logic                in_service_q, in_service_d;
   logic [PCW-1:0]      pc_snap_q, pc_snap_d;
   logic [FLAG_W-1:0]   ccr_snap_q, ccr_snap_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PCW-1:0]      pop_pc_q, pop_pc_d;
   logic [FLAG_W-1:0]   pop_ccr_q, pop_ccr_d;

   logic [N_IRQ-1:0]    irq_rise;
   logic [N_IRQ-1:0]    eligible;
   logic [N_IRQ-1:0]    take_clr;
   logic                win_valid;
   logic [ID_W-1:0]     win_id;
   logic                take;
   int                  push_idx;

   // A level already high when reset releases is not treated as a new edge.
   assign irq_rise = arm_q ? (irq & ~irq_q) : '0;
   assign eligible = pend_q & ~irq_mask;
   assign take_clr = take ? (N_IRQ'(1) << win_id) : '0;
   assign pend_d   = (pend_q & ~take_clr) | irq_rise;
   assign push_idx = (cnt_q < LAST_WORD) ? (PC_WORDS - 1 - int'(cnt_q)) : 0;

   irq_priority_encoder #(
      .N_IRQ (N_IRQ),
      .ID_W  (ID_W)
   ) u_prio (
      .req_i   (eligible),
      .valid_o (win_valid),
      .id_o    (win_id)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         irq_q        <= '0;
         arm_q        <= 1'b0;
         pend_q       <= '0;
         active_id_q  <= '0;
         in_service_q <= 1'b0;
         pc_snap_q    <= '0;
         ccr_snap_q   <= '0;
         cnt_q        <= '0;
         pop_pc_q     <= '0;
         pop_ccr_q    <= '0;
      end else begin
         state_q      <= state_d;
         irq_q        <= irq;
         arm_q        <= 1'b1;
         pend_q       <= pend_d;
         active_id_q  <= active_id_d;
         in_service_q <= in_service_d;
         pc_snap_q    <= pc_snap_d;
         ccr_snap_q   <= ccr_snap_d;
         cnt_q        <= cnt_d;
         pop_pc_q     <= pop_pc_d;
         pop_ccr_q    <= pop_ccr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      active_id_d  = active_id_q;
      in_service_d = in_service_q;
      pc_snap_d    = pc_snap_q;
      ccr_snap_d   = ccr_snap_q;
      cnt_d        = cnt_q;
      pop_pc_d     = pop_pc_q;
      pop_ccr_d    = pop_ccr_q;
      take         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // RTI is checked first so it wins over a request in the same cycle.
            if (in_service_q) begin
               if (rti) begin
                  state_d = S_POP;
                  cnt_d   = '0;
               end
            end else if (win_valid && !branch_pending) begin
               take        = 1'b1;
               active_id_d = win_id;
               pc_snap_d   = PCW'(pc_resume);
               ccr_snap_d  = ccr_in;
               cnt_d       = '0;
               state_d     = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               cnt_d   = '0;
               state_d = S_PUSH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PUSH: begin
            if (push_ready) begin
               if (cnt_q == LAST_WORD) begin
                  cnt_d   = '0;
                  state_d = S_VECTOR;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_VECTOR: begin
            in_service_d = 1'b1;
            state_d      = S_IDLE;
         end
         S_POP: begin
            if (pop_valid) begin
               if (cnt_q == '0) begin
                  pop_ccr_d = pop_data[FLAG_W-1:0];
               end else begin
                  pop_pc_d[(int'(cnt_q) - 1) * DATA_W +: DATA_W] = pop_data;
               end
               if (cnt_q == LAST_WORD) begin
                  cnt_d   = '0;
                  state_d = S_RESUME;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_RESUME: begin
            in_service_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall_fetch    = 1'b0;
      flush          = 1'b0;
      push_req       = 1'b0;
      push_data      = '0;
      pop_req        = 1'b0;
      pc_load        = 1'b0;
      pc_load_value  = '0;
      ccr_load       = 1'b0;
      ccr_load_value = '0;
      spurious_rti   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rti) begin
               if (in_service_q) begin
                  stall_fetch = 1'b1;
                  flush       = 1'b1;
               end else begin
                  spurious_rti = 1'b1;
               end
            end
         end
         S_DRAIN: stall_fetch = 1'b1;
         S_PUSH: begin
            stall_fetch = 1'b1;
            push_req    = 1'b1;
            push_data   = (cnt_q < LAST_WORD) ? pc_snap_q[push_idx * DATA_W +: DATA_W]
                                              : DATA_W'(ccr_snap_q);
         end
         S_VECTOR: begin
            stall_fetch   = 1'b1;
            flush         = 1'b1;
            pc_load       = 1'b1;
            pc_load_value = ADDR_W'(VEC_BASE) + ADDR_W'(active_id_q) * ADDR_W'(VEC_STRIDE);
         end
         S_POP: begin
            stall_fetch = 1'b1;
            pop_req     = 1'b1;
         end
         S_RESUME: begin
            stall_fetch    = 1'b1;
            pc_load        = 1'b1;
            pc_load_value  = pop_pc_q[ADDR_W-1:0];
            ccr_load       = 1'b1;
            ccr_load_value = pop_ccr_q;
         end
         default: stall_fetch = 1'b0;
      endcase
   end

   assign in_service = in_service_q;
   assign active_id  = active_id_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: entry, priority, backpressure, RTI restore,
// deferral, masking, spurious RTI and mid-sequence reset.
module tb_irq_sequencer;
   import irq_sequencer_pkg::*;

   logic        clk;
   logic        reset;
   logic [3:0]  irq;
   logic [3:0]  irq_mask;
   logic [31:0] pc_resume;
   logic [2:0]  ccr_in;
   logic        branch_pending;
   logic        rti;
   logic        push_ready;
   logic        pop_valid;
   logic [15:0] pop_data;
   logic        stall_fetch;
   logic        flush;
   logic        push_req;
   logic [15:0] push_data;
   logic        pop_req;
   logic        pc_load;
   logic [31:0] pc_load_value;
   logic        ccr_load;
   logic [2:0]  ccr_load_value;
   logic        in_service;
   logic [1:0]  active_id;
   logic        spurious_rti;
   state_t      dbg_state;
   logic [60:0] out_bus;

   int vectors = 0;
   int miscompares = 0;
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];

   assign out_bus = {stall_fetch, flush, push_req, push_data, pop_req, pc_load, pc_load_value,
                     ccr_load, ccr_load_value, in_service, active_id, spurious_rti};

   irq_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .irq            (irq),
      .irq_mask       (irq_mask),
      .pc_resume      (pc_resume),
      .ccr_in         (ccr_in),
      .branch_pending (branch_pending),
      .rti            (rti),
      .push_ready     (push_ready),
      .pop_valid      (pop_valid),
      .pop_data       (pop_data),
      .stall_fetch    (stall_fetch),
      .flush          (flush),
      .push_req       (push_req),
      .push_data      (push_data),
      .pop_req        (pop_req),
      .pc_load        (pc_load),
      .pc_load_value  (pc_load_value),
      .ccr_load       (ccr_load),
      .ccr_load_value (ccr_load_value),
      .in_service     (in_service),
      .active_id      (active_id),
      .spurious_rti   (spurious_rti),
      .dbg_state      (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Follows an entry sequence from IDLE to the vector cycle; records only.
   task automatic do_entry(output int drain_n, output int push_n, output logic [31:0] vec,
                           output logic vflush, output bit to);
      int guard;
      drain_n = 0; push_n = 0; vec = '0; vflush = 1'b0; to = 1'b0; guard = 0;
      got_q.delete();
      while (!stall_fetch && guard < 20) begin tick(); guard++; end
      while (stall_fetch && !push_req && !pc_load && guard < 40) begin
         drain_n++; tick(); guard++;
      end
      while (!pc_load && guard < 80) begin
         if (push_req && push_ready) begin got_q.push_back(push_data); push_n++; end
         tick(); guard++;
      end
      if (pc_load) begin vec = pc_load_value; vflush = flush; end
      else to = 1'b1;
      tick();
   endtask

   // Issues RTI, feeds three pop beats and records the restore cycle.
   task automatic do_exit(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                          input logic [3:0] irq_with, output logic es, output logic ef,
                          output int pops, output logic [31:0] pcv, output logic [2:0] ccrv,
                          output logic ccrl, output bit to);
      logic [15:0] d[3];
      int guard;
      d[0] = d0; d[1] = d1; d[2] = d2;
      pops = 0; pcv = '0; ccrv = '0; ccrl = 1'b0; to = 1'b0; guard = 0;
      rti = 1'b1; irq = irq_with;
      #1;
      es = stall_fetch; ef = flush;
      tick();
      rti = 1'b0; irq = 4'b0000;
      while (!pc_load && guard < 40) begin
         if (pop_req && pops < 3) begin pop_valid = 1'b1; pop_data = d[pops]; pops++; end
         else pop_valid = 1'b0;
         tick(); guard++;
      end
      pop_valid = 1'b0;
      if (pc_load) begin pcv = pc_load_value; ccrv = ccr_load_value; ccrl = ccr_load; end
      else to = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      vectors++;
      if (out_bus !== '0) begin
         miscompares++; $display("FAIL reset_outputs: got %h expected 0", out_bus);
      end
      vectors++;
      if (dbg_state !== S_IDLE) begin
         miscompares++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
      end
      reset = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_entry();
      int dn, pn; logic [31:0] vec; logic vfl; bit to;
      pc_resume = 32'h0001_2345; ccr_in = 3'b101; push_ready = 1'b1; irq_mask = 4'b0000;
      irq = 4'b0100; tick(); irq = 4'b0000;
      exp_q.push_back(16'h0001); exp_q.push_back(16'h2345); exp_q.push_back(16'h0005);
      do_entry(dn, pn, vec, vfl, to);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("FAIL entry_timeout: got %0d expected 0", to); end
      vectors++;
      if (dn !== 3) begin miscompares++; $display("FAIL entry_drain: got %0d expected 3", dn); end
      vectors++;
      if (pn !== 3) begin miscompares++; $display("FAIL entry_pushes: got %0d expected 3", pn); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [15:0] e, g;
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++;
         if (g !== e) begin miscompares++; $display("FAIL entry_word: got %h expected %h", g, e); end
      end
      exp_q.delete();
      vectors++;
      if (vec !== 32'h4) begin miscompares++; $display("FAIL entry_vector: got %h expected 4", vec); end
      vectors++;
      if (vfl !== 1'b1) begin miscompares++; $display("FAIL entry_flush: got %0d expected 1", vfl); end
      vectors++;
      if ({in_service, active_id, stall_fetch} !== {1'b1, 2'd2, 1'b0}) begin
         miscompares++;
         $display("FAIL entry_service: got %b/%0d/%b expected 1/2/0", in_service, active_id, stall_fetch);
      end
   endtask

   task automatic test_exit();
      logic es, ef, ccrl; int pops; logic [31:0] pcv; logic [2:0] ccrv; bit to;
      pop_valid = 1'b1; pop_data = 16'hFFFF;
      tick();
      pop_valid = 1'b0;
      vectors++;
      if ({in_service, pop_req, pc_load} !== 3'b100) begin
         miscompares++; $display("FAIL exit_stray_pop: got %b expected 100", {in_service, pop_req, pc_load});
      end
      do_exit(16'h0006, 16'h0010, 16'h0000, 4'b0000, es, ef, pops, pcv, ccrv, ccrl, to);
      vectors++;
      if ({es, ef} !== 2'b11) begin miscompares++; $display("FAIL exit_entry_stall: got %b expected 11", {es, ef}); end
      vectors++;
      if (to !== 1'b0 || pops !== 3) begin
         miscompares++; $display("FAIL exit_pops: got %0d (to=%0d) expected 3", pops, to);
      end
      vectors++;
      if (pcv !== 32'h0000_0010) begin miscompares++; $display("FAIL exit_pc: got %h expected 00000010", pcv); end
      vectors++;
      if ({ccrl, ccrv} !== {1'b1, 3'b110}) begin
         miscompares++; $display("FAIL exit_ccr: got %b/%b expected 1/110", ccrl, ccrv);
      end
      vectors++;
      if ({in_service, stall_fetch} !== 2'b00) begin
         miscompares++; $display("FAIL exit_service: got %b expected 00", {in_service, stall_fetch});
      end
   endtask

   task automatic test_priority();
      int dn, pn; logic [31:0] vec; logic vfl; bit to;
      logic es, ef, ccrl; int pops; logic [31:0] pcv; logic [2:0] ccrv;
      pc_resume = 32'h0000_0100; ccr_in = 3'b011; push_ready = 1'b1;
      irq = 4'b1010; tick(); irq = 4'b0000;
      exp_q.push_back(16'h0000); exp_q.push_back(16'h0100); exp_q.push_back(16'h0003);
      do_entry(dn, pn, vec, vfl, to);
      vectors++;
      if ({vec, active_id} !== {32'h2, 2'd1}) begin
         miscompares++; $display("FAIL prio_first: got %h/%0d expected 2/1", vec, active_id);
      end
      vectors++;
      if (got_q.size() !== 3) begin miscompares++; $display("FAIL prio_pushes: got %0d expected 3", got_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [15:0] e, g;
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++;
         if (g !== e) begin miscompares++; $display("FAIL prio_word: got %h expected %h", g, e); end
      end
      exp_q.delete();
      do_exit(16'h0003, 16'hABCD, 16'h1234, 4'b0000, es, ef, pops, pcv, ccrv, ccrl, to);
      vectors++;
      if ({pcv, ccrv} !== {32'h1234_ABCD, 3'b011}) begin
         miscompares++; $display("FAIL prio_restore: got %h/%b expected 1234abcd/011", pcv, ccrv);
      end
      vectors++;
      if ({stall_fetch, in_service} !== 2'b00) begin
         miscompares++; $display("FAIL prio_idle_gap: got %b expected 00", {stall_fetch, in_service});
      end
      tick();
      vectors++;
      if (stall_fetch !== 1'b1) begin miscompares++; $display("FAIL prio_back_to_back: got %b expected 1", stall_fetch); end
      do_entry(dn, pn, vec, vfl, to);
      vectors++;
      if ({dn, vec, active_id} !== {32'd3, 32'h6, 2'd3}) begin
         miscompares++; $display("FAIL prio_second: got %0d/%h/%0d expected 3/6/3", dn, vec, active_id);
      end
      do_exit(16'h0000, 16'h0000, 16'h0000, 4'b0000, es, ef, pops, pcv, ccrv, ccrl, to);
   endtask

   task automatic test_back_to_back_stall();
      int accepted, held, low_cnt, guard; logic [15:0] ccr_word; logic saw_vec;
      logic es, ef, ccrl; int pops; logic [31:0] pcv; logic [2:0] ccrv; bit to;
      pc_resume = 32'h0001_2345; ccr_in = 3'b101; push_ready = 1'b1;
      irq = 4'b0001; tick(); irq = 4'b0000;
      accepted = 0; held = 0; low_cnt = 0; guard = 0; ccr_word = '0;
      while (!pc_load && guard < 60) begin
         if (push_req) begin
            if (accepted == 1 && low_cnt < 2) begin push_ready = 1'b0; low_cnt++; end
            else push_ready = 1'b1;
            if (accepted == 1 && push_data == 16'h2345) held++;
            if (accepted == 2) ccr_word = push_data;
            if (push_ready) accepted++;
         end
         tick(); guard++;
      end
      saw_vec = pc_load;
      vectors++;
      if (held !== 3) begin miscompares++; $display("FAIL bp_hold: got %0d expected 3", held); end
      vectors++;
      if (accepted !== 3) begin miscompares++; $display("FAIL bp_accepted: got %0d expected 3", accepted); end
      vectors++;
      if (ccr_word !== 16'h0005) begin miscompares++; $display("FAIL bp_ccr_word: got %h expected 0005", ccr_word); end
      vectors++;
      if ({saw_vec, pc_load_value} !== {1'b1, 32'h0}) begin
         miscompares++; $display("FAIL bp_vector: got %b/%h expected 1/0", saw_vec, pc_load_value);
      end
      push_ready = 1'b1;
      tick();
      do_exit(16'h0000, 16'h0000, 16'h0000, 4'b0000, es, ef, pops, pcv, ccrv, ccrl, to);
   endtask

   task automatic test_defer_and_mask();
      int dn, pn; logic [31:0] vec; logic vfl; bit to;
      logic es, ef, ccrl; int pops; logic [31:0] pcv; logic [2:0] ccrv;
      branch_pending = 1'b1; irq = 4'b0100; tick(); irq = 4'b0000;
      tick(); tick();
      vectors++;
      if (stall_fetch !== 1'b0) begin miscompares++; $display("FAIL defer_hold: got %b expected 0", stall_fetch); end
      branch_pending = 1'b0;
      tick();
      vectors++;
      if (stall_fetch !== 1'b1) begin miscompares++; $display("FAIL defer_release: got %b expected 1", stall_fetch); end
      do_entry(dn, pn, vec, vfl, to);
      vectors++;
      if (vec !== 32'h4) begin miscompares++; $display("FAIL defer_vector: got %h expected 4", vec); end
      do_exit(16'h0000, 16'h0000, 16'h0000, 4'b0000, es, ef, pops, pcv, ccrv, ccrl, to);
      irq_mask = 4'b0001; irq = 4'b0001; tick(); irq = 4'b0000;
      repeat (4) tick();
      vectors++;
      if (stall_fetch !== 1'b0) begin miscompares++; $display("FAIL mask_hold: got %b expected 0", stall_fetch); end
      irq_mask = 4'b0000;
      tick();
      vectors++;
      if (stall_fetch !== 1'b1) begin miscompares++; $display("FAIL mask_release: got %b expected 1", stall_fetch); end
      do_entry(dn, pn, vec, vfl, to);
      vectors++;
      if ({vec, active_id} !== {32'h0, 2'd0}) begin
         miscompares++; $display("FAIL mask_vector: got %h/%0d expected 0/0", vec, active_id);
      end
      // RTI together with a fresh edge: the RTI is honoured, the edge waits.
      do_exit(16'h0000, 16'h0000, 16'h0000, 4'b0100, es, ef, pops, pcv, ccrv, ccrl, to);
      vectors++;
      if ({to, pops} !== {1'b0, 32'd3}) begin
         miscompares++; $display("FAIL rti_wins: got to=%0d pops=%0d expected 0/3", to, pops);
      end
      do_entry(dn, pn, vec, vfl, to);
      vectors++;
      if ({to, vec} !== {1'b0, 32'h4}) begin
         miscompares++; $display("FAIL rti_irq_kept: got to=%0d vec=%h expected 0/4", to, vec);
      end
      do_exit(16'h0000, 16'h0000, 16'h0000, 4'b0000, es, ef, pops, pcv, ccrv, ccrl, to);
   endtask

   task automatic test_spurious();
      logic busy;
      rti = 1'b1;
      #1;
      vectors++;
      if ({spurious_rti, pop_req, pc_load, stall_fetch} !== 4'b1000) begin
         miscompares++;
         $display("FAIL spurious_pulse: got %b expected 1000", {spurious_rti, pop_req, pc_load, stall_fetch});
      end
      tick();
      rti = 1'b0;
      #1;
      busy = spurious_rti;
      repeat (3) begin
         tick();
         busy = busy | pop_req | pc_load | stall_fetch | spurious_rti;
      end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL spurious_after: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid_push();
      int guard; logic retaken;
      pc_resume = 32'h0001_2345; ccr_in = 3'b101; push_ready = 1'b0;
      irq = 4'b0100; guard = 0;
      tick();
      while (!push_req && guard < 20) begin tick(); guard++; end
      vectors++;
      if ({push_req, push_data} !== {1'b1, 16'h0001}) begin
         miscompares++; $display("FAIL rst_mid_word1: got %b/%h expected 1/0001", push_req, push_data);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (out_bus !== '0) begin miscompares++; $display("FAIL rst_mid_outputs: got %h expected 0", out_bus); end
      tick();
      reset = 1'b0; push_ready = 1'b1; retaken = 1'b0;
      repeat (8) begin tick(); retaken = retaken | stall_fetch; end
      vectors++;
      if (retaken !== 1'b0) begin miscompares++; $display("FAIL rst_mid_retake: got %b expected 0", retaken); end
      irq = 4'b0000;
      tick();
   endtask

   initial begin
      reset = 1'b1; irq = '0; irq_mask = '0; pc_resume = '0; ccr_in = '0;
      branch_pending = 1'b0; rti = 1'b0; push_ready = 1'b0; pop_valid = 1'b0; pop_data = '0;
      test_reset();
      test_entry();
      test_exit();
      test_priority();
      test_back_to_back_stall();
      test_defer_and_mask();
      test_spurious();
      test_reset_mid_push();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
